// File: rtl/gate_self_test.sv
// Start/done self-test engine for the two-input basic-gate block: drives all four {a,b}
// vectors, samples the five gate outputs and checks them. Option: GATE_ST_HALT_ON_ERR_EN.
module gate_self_test #(
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned LOOPS      = 1,
   parameter int unsigned ERR_W      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a_o,
   output logic             b_o,
   input  logic             an_i,
   input  logic             o_i,
   input  logic             nt_i,
   input  logic             xr_i,
   input  logic             xnr_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [3:0]       fail_vec
);

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);
   localparam logic [3:0] LOOP_LAST = 4'(LOOPS - 1);
`ifdef GATE_ST_HALT_ON_ERR_EN
   localparam bit HALT_ON_ERR = 1'b1;
`else
   localparam bit HALT_ON_ERR = 1'b0;
`endif

   state_t           state, state_nxt;
   logic [1:0]       vec, vec_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic [3:0]       loop, loop_nxt;
   logic [ERR_W-1:0] err_cnt_nxt, err_inc;
   logic [3:0]       fail_vec_nxt;
   logic             pass_nxt;
   logic [4:0]       golden, observed;
   logic             mismatch;

   assign golden   = {vec[1] & vec[0], vec[1] | vec[0], ~vec[1],
                      vec[1] ^ vec[0], ~(vec[1] ^ vec[0])};
   assign observed = {an_i, o_i, nt_i, xr_i, xnr_i};
   assign mismatch = (golden != observed);
   assign err_inc  = (&err_cnt) ? err_cnt : err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};

   assign a_o  = vec[1];
   assign b_o  = vec[0];
   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         vec      <= '0;
         cnt      <= '0;
         loop     <= '0;
         err_cnt  <= '0;
         fail_vec <= '0;
         pass     <= 1'b0;
      end else begin
         state    <= state_nxt;
         vec      <= vec_nxt;
         cnt      <= cnt_nxt;
         loop     <= loop_nxt;
         err_cnt  <= err_cnt_nxt;
         fail_vec <= fail_vec_nxt;
         pass     <= pass_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      vec_nxt      = vec;
      cnt_nxt      = cnt;
      loop_nxt     = loop;
      err_cnt_nxt  = err_cnt;
      fail_vec_nxt = fail_vec;
      pass_nxt     = pass;
      case (state)
         IDLE: begin
            if (start) begin
               err_cnt_nxt  = '0;
               fail_vec_nxt = '0;
               pass_nxt     = 1'b0;
               vec_nxt      = '0;
               loop_nxt     = '0;
               cnt_nxt      = SETTLE_LD;
               state_nxt    = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt <= 4'd1) state_nxt = CHECK;
            else             cnt_nxt   = cnt - 4'd1;
         end
         CHECK: begin
            if (mismatch) begin
               err_cnt_nxt       = err_inc;
               fail_vec_nxt[vec] = 1'b1;
            end
            // pass must account for the check being made in this same cycle
            if (HALT_ON_ERR && mismatch) begin
               pass_nxt  = 1'b0;
               state_nxt = DONE;
            end else if (vec != 2'd3) begin
               vec_nxt   = vec + 2'd1;
               cnt_nxt   = SETTLE_LD;
               state_nxt = SETTLE;
            end else if (loop < LOOP_LAST) begin
               vec_nxt   = '0;
               loop_nxt  = loop + 4'd1;
               cnt_nxt   = SETTLE_LD;
               state_nxt = SETTLE;
            end else begin
               pass_nxt  = !mismatch && (err_cnt == '0);
               state_nxt = DONE;
            end
         end
         DONE: begin
            vec_nxt   = '0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
